// File: rtl/hex_seq_pkg.sv
// Shared types and constants for the hex digit sequencer.
// Define BCD_MODE_EN to restrict the digit range to 0..9.
package hex_seq_pkg;

  localparam int DIGIT_W = 4;

`ifdef BCD_MODE_EN
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
`else
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd15;
`endif

  typedef enum logic [1:0] {SRC_NONE, SRC_LOAD, SRC_STEP} step_src_e;

  // Out-of-range load values collapse to zero so the digit never leaves its range.
  function automatic logic [DIGIT_W-1:0] clamp_load(input logic [DIGIT_W-1:0] v);
`ifdef BCD_MODE_EN
    return (v > DIGIT_MAX) ? '0 : v;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample that agrees with the current level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/hex_digit_sequencer.sv
// Digit source for the 7-segment decoder: steps on button, auto tick or load.
// Define BCD_MODE_EN for a 0..9 count range; ports are unchanged.
module hex_digit_sequencer
  import hex_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_btn,
  input  logic               dir,
  input  logic               auto_en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_stb,
  output logic               carry
);

  logic                  step_pulse;
  logic                  auto_tick;
  step_src_e             src;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic                  stb_q, stb_d;
  logic                  carry_q, carry_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (step_btn),
    .btn_pulse(step_pulse)
  );

  always_comb begin
    pre_d     = auto_en ? pre_q + PRESCALE_W'(1) : '0;
    auto_tick = auto_en && (pre_q == '1);

    // Load wins; simultaneous button and auto requests merge into one step.
    if (load)                         src = SRC_LOAD;
    else if (step_pulse || auto_tick) src = SRC_STEP;
    else                              src = SRC_NONE;

    digit_d = digit_q;
    stb_d   = 1'b0;
    carry_d = 1'b0;
    case (src)
      SRC_LOAD: begin
        digit_d = clamp_load(load_val);
        stb_d   = 1'b1;
      end
      SRC_STEP: begin
        stb_d = 1'b1;
        if (dir) begin
          if (digit_q == '0) begin
            digit_d = DIGIT_MAX;
            carry_d = 1'b1;
          end else begin
            digit_d = digit_q - DIGIT_W'(1);
          end
        end else begin
          if (digit_q == DIGIT_MAX) begin
            digit_d = '0;
            carry_d = 1'b1;
          end else begin
            digit_d = digit_q + DIGIT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      digit_q <= '0;
      stb_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      stb_q   <= stb_d;
      carry_q <= carry_d;
    end
  end

  assign digit     = digit_q;
  assign digit_stb = stb_q;
  assign carry     = carry_q;

endmodule
